// File: rtl/hpdcache_sync_buffer_rr_arb.sv
// Round-robin arbiter sharing one single-entry buffer between N requesters;
// the winning payload leaves, tagged with its requester index, on one valid/ready channel.
module hpdcache_sync_buffer_rr_arb #(
  parameter int unsigned N           = 4,
  parameter bit          FEEDTHROUGH = 1'b0,
  parameter type         data_t      = logic,
  parameter int unsigned ID_W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_valid_i,
  output logic [N-1:0]    req_ready_o,
  input  data_t           req_data_i [N],
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output data_t           out_data_o,
  output logic [ID_W-1:0] out_id_o
);

  logic            valid_q;
  logic            valid_d;
  data_t           buf_q;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] prio_q;
  logic [ID_W-1:0] prio_d;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_idx;
  logic            wok;
  logic            hs;
  logic            we;

  always_comb begin : grant_scan
    int              idx;
    logic [ID_W-1:0] idx_w;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    idx_w   = '0;
    // Scan downward so the candidate closest to prio_q is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(prio_q) + k;
      if (idx >= int'(N)) idx = idx - int'(N);
      idx_w = ID_W'(idx);
      if (req_valid_i[idx_w]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx_w;
      end
    end
  end

  always_comb begin : write_ctrl
    wok = ~valid_q | (FEEDTHROUGH & out_ready_i);
    hs  = gnt_vld & wok;
    req_ready_o = '0;
    if (hs) req_ready_o[gnt_idx] = 1'b1;
    // With feedthrough, an empty buffer read in the same cycle lets the payload bypass storage.
    if (FEEDTHROUGH) we = hs & ~(valid_q ^ out_ready_i);
    else             we = hs & ~valid_q;
    valid_d = we | (valid_q & ~out_ready_i);
    prio_d  = prio_q;
    if (hs) prio_d = (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      prio_q  <= '0;
    end else begin
      valid_q <= valid_d;
      prio_q  <= prio_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      buf_q <= req_data_i[gnt_idx];
      id_q  <= gnt_idx;
    end
  end

  always_comb begin : out_mux
    out_valid_o = valid_q | (FEEDTHROUGH & (|req_valid_i));
    out_data_o  = buf_q;
    out_id_o    = id_q;
    if (FEEDTHROUGH && !valid_q) begin
      out_data_o = req_data_i[gnt_idx];
      out_id_o   = gnt_idx;
    end
  end

endmodule

// File: tb/tb_hpdcache_sync_buffer_rr_arb.sv
// Bench for hpdcache_sync_buffer_rr_arb: one instance without and one with feedthrough,
// directed scenarios then random traffic against a transaction-level model.
module tb_hpdcache_sync_buffer_rr_arb;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] tv [2];
  logic [7:0]   td [2][N];
  logic         tr [2];

  logic [7:0]   rd0 [N];
  logic [7:0]   rd1 [N];
  logic [N-1:0] rdy0, rdy1;
  logic         ovld0, ovld1;
  logic [7:0]   odat0, odat1;
  logic [1:0]   oid0, oid1;

  for (genvar i = 0; i < N; i++) begin : g_data
    assign rd0[i] = td[0][i];
    assign rd1[i] = td[1][i];
  end

  hpdcache_sync_buffer_rr_arb #(.N(N), .FEEDTHROUGH(1'b0), .data_t(logic [7:0])) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(tv[0]), .req_ready_o(rdy0), .req_data_i(rd0),
    .out_valid_o(ovld0), .out_ready_i(tr[0]), .out_data_o(odat0), .out_id_o(oid0));

  hpdcache_sync_buffer_rr_arb #(.N(N), .FEEDTHROUGH(1'b1), .data_t(logic [7:0])) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(tv[1]), .req_ready_o(rdy1), .req_data_i(rd1),
    .out_valid_o(ovld1), .out_ready_i(tr[1]), .out_data_o(odat1), .out_id_o(oid1));

  int n_chk = 0;
  int n_err = 0;

  // Transaction-level model: a one-slot queue per instance plus a priority pointer.
  bit         mfull [2];
  logic [7:0] mbuf  [2];
  int         mid   [2];
  int         mprio [2];
  bit         l_hs  [2];
  int         l_g   [2];

  logic [N-1:0] s_rdy [2];
  logic         s_ovld [2];
  logic [7:0]   s_odat [2];
  logic [1:0]   s_oid [2];
  logic         s_vq [2];
  logic [1:0]   s_pr [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string tg(input int u, input string s);
    return $sformatf("ft%0d_%s", u, s);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mfull[u] = 1'b0;
      mprio[u] = 0;
    end
  endtask

  task automatic step();
    int g;
    bit ft, wok, ev, byp;
    logic [N-1:0] er;
    bit hs [2];
    bit cons [2];
    int gg [2];
    @(negedge clk);
    s_rdy[0] = rdy0;   s_rdy[1] = rdy1;
    s_ovld[0] = ovld0; s_ovld[1] = ovld1;
    s_odat[0] = odat0; s_odat[1] = odat1;
    s_oid[0] = oid0;   s_oid[1] = oid1;
    s_vq[0] = dut0.valid_q; s_vq[1] = dut1.valid_q;
    s_pr[0] = dut0.prio_q;  s_pr[1] = dut1.prio_q;
    for (int u = 0; u < 2; u++) begin
      ft = (u == 1);
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && tv[u][(mprio[u] + k) % N]) g = (mprio[u] + k) % N;
      wok   = !mfull[u] || (ft && tr[u]);
      hs[u] = (g >= 0) && wok;
      er = '0;
      if (hs[u]) er[g] = 1'b1;
      ev = mfull[u] || (ft && g >= 0);
      check(tg(u, "rdy"),  32'(s_rdy[u]),  32'(er));
      check(tg(u, "ovld"), 32'(s_ovld[u]), 32'(ev));
      check(tg(u, "vq"),   32'(s_vq[u]),   32'(mfull[u]));
      check(tg(u, "prio"), 32'(s_pr[u]),   32'(mprio[u]));
      if (ev) begin
        check(tg(u, "odat"), 32'(s_odat[u]), mfull[u] ? 32'(mbuf[u]) : 32'(td[u][g]));
        check(tg(u, "oid"),  32'(s_oid[u]),  mfull[u] ? 32'(mid[u])  : 32'(g));
      end
      cons[u] = ev && tr[u];
      gg[u]   = g;
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      ft = (u == 1);
      if (!rst_n) begin
        mfull[u] = 1'b0;
        mprio[u] = 0;
      end else begin
        byp = hs[u] && !mfull[u] && ft && tr[u];
        if (mfull[u] && cons[u]) mfull[u] = 1'b0;
        if (hs[u]) begin
          mprio[u] = (gg[u] + 1) % N;
          if (!byp) begin
            mfull[u] = 1'b1;
            mbuf[u]  = td[u][gg[u]];
            mid[u]   = gg[u];
          end
        end
      end
      l_hs[u] = hs[u];
      l_g[u]  = gg[u];
    end
    #1;
  endtask

  logic [3:0] t1_rdy [9];
  logic [3:0] t2_rdy [6];

  initial begin
    t1_rdy = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    t2_rdy = '{4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b1000};
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      tv[u] = '0;
      tr[u] = 1'b1;
      l_hs[u] = 1'b0;
      l_g[u] = 0;
      mbuf[u] = '0;
      mid[u] = 0;
      for (int i = 0; i < N; i++) td[u][i] = '0;
    end
    model_reset();
    #1;
    check("rst_ovld0", 32'(ovld0), 32'd0);
    check("rst_ovld1", 32'(ovld1), 32'd0);
    step();
    tv[0] = 4'b0100;
    step();
    check("rst_rdy_winner", 32'(s_rdy[0]), 32'b0100);

    // Reset release: all four requesters contend, FEEDTHROUGH=0.
    rst_n = 1'b1;
    tv[0] = 4'b1111;
    for (int i = 0; i < N; i++) td[0][i] = 8'hA0 + 8'(i);
    for (int c = 0; c < 9; c++) begin
      step();
      check("t1_rdy", 32'(s_rdy[0]), 32'(t1_rdy[c]));
      check("t1_ovld", 32'(s_ovld[0]), 32'(c % 2));
      if (c % 2 == 1) begin
        check("t1_oid", 32'(s_oid[0]), 32'((c - 1) / 2));
        check("t1_odat", 32'(s_odat[0]), 32'(8'hA0 + 8'((c - 1) / 2)));
      end
    end

    // Fairness skip: move pointer to 2, then only 1 and 3 request.
    tv[0] = 4'b0010;
    step();
    step();
    check("t2_pre_rdy", 32'(s_rdy[0]), 32'b0010);
    tv[0] = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      step();
      check("t2_rdy", 32'(s_rdy[0]), 32'(t2_rdy[c]));
    end

    // Back-pressure, feedthrough instance first so instance 0 stays full for the reset test.
    for (int u = 1; u >= 0; u--) begin
      tv[u] = '0;
      tr[u] = 1'b1;
      step();
      tv[u] = 4'b0100;
      td[u][2] = 8'h22;
      tr[u] = 1'b0;
      step();
      check(tg(u, "t3_store"), 32'(s_rdy[u]), 32'b0100);
      tv[u] = 4'b0001;
      td[u][0] = 8'h11;
      for (int c = 0; c < 5; c++) begin
        step();
        check(tg(u, "t3_bp_rdy"), 32'(s_rdy[u]), 32'd0);
        check(tg(u, "t3_bp_oid"), 32'(s_oid[u]), 32'd2);
        check(tg(u, "t3_bp_odat"), 32'(s_odat[u]), 32'h22);
      end
      tr[u] = 1'b1;
      step();
      check(tg(u, "t3_rel_oid"), 32'(s_oid[u]), 32'd2);
      check(tg(u, "t3_rel_rdy"), 32'(s_rdy[u]), (u == 1) ? 32'b0001 : 32'd0);
      if (u == 0) begin
        step();
        check("ft0_t3_next_rdy", 32'(s_rdy[0]), 32'b0001);
      end
      tv[u] = '0;
      if (u == 1) begin
        // Streaming through an empty buffer.
        step();
        tv[1] = 4'b0100;
        for (int c = 0; c < 4; c++) begin
          td[1][2] = 8'h30 + 8'(c);
          step();
          check("t4_vq", 32'(s_vq[1]), 32'd0);
          check("t4_ovld", 32'(s_ovld[1]), 32'd1);
          check("t4_oid", 32'(s_oid[1]), 32'd2);
          check("t4_odat", 32'(s_odat[1]), 32'(8'h30 + 8'(c)));
        end
        // Store while blocked, then drain and refill in one cycle.
        tv[1] = 4'b0010;
        td[1][1] = 8'h55;
        tr[1] = 1'b0;
        step();
        check("t5_store_rdy", 32'(s_rdy[1]), 32'b0010);
        tv[1] = 4'b0001;
        td[1][0] = 8'h66;
        tr[1] = 1'b1;
        step();
        check("t5_vq", 32'(s_vq[1]), 32'd1);
        check("t5_odat", 32'(s_odat[1]), 32'h55);
        check("t5_oid", 32'(s_oid[1]), 32'd1);
        check("t5_rdy", 32'(s_rdy[1]), 32'b0001);
        tv[1] = '0;
        tr[1] = 1'b0;
        step();
        check("t5_vq2", 32'(s_vq[1]), 32'd1);
        check("t5_oid2", 32'(s_oid[1]), 32'd0);
        check("t5_odat2", 32'(s_odat[1]), 32'h66);
        tr[1] = 1'b1;
        step();
      end
    end

    // Reset while full and back-pressured.
    tr[0] = 1'b0;
    step();
    check("t6_pre_vq", 32'(s_vq[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_vq", 32'(dut0.valid_q), 32'd0);
    check("t6_prio", 32'(dut0.prio_q), 32'd0);
    check("t6_ovld", 32'(ovld0), 32'd0);
    tv[0] = 4'b1111;
    step();
    rst_n = 1'b1;
    tr[0] = 1'b1;
    step();
    check("t6_first", 32'(s_rdy[0]), 32'b0001);

    // Random traffic honouring the hold-until-ready rule.
    for (int c = 0; c < 600; c++) begin
      for (int u = 0; u < 2; u++) begin
        for (int i = 0; i < N; i++) begin
          if (!tv[u][i] || (l_hs[u] && l_g[u] == i)) begin
            tv[u][i] = ($urandom_range(0, 2) != 0);
            td[u][i] = 8'($urandom);
          end
        end
        tr[u] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hpdcache_sync_buffer_rr_arb.md
# hpdcache_sync_buffer_rr_arb

Round-robin arbiter that shares one single-entry synchronization buffer between N requesters and drives the winning payload, tagged with its requester index, onto one downstream valid/ready channel. The arbiter sequences all writes into the buffer and owns its valid state. The block sits in front of shared single-port consumers in the cache, such as the miss-handler request port and the uncached/AMO request port, where several sources contend for one registered slot.

## Interface

**Parameters**
- `N`, default 4: number of requesters; legal range 1..16.
- `FEEDTHROUGH`, default 1'b0: when 1, an empty buffer passes the granted request combinationally to the output.
- `data_t`, default logic: payload type.
- `ID_W`, default max(1, $clog2(N)): requester index width. Derived; do not override.

**Ports** (name, direction, width, meaning)
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_ni` input 1: asynchronous reset, active-low.
- `req_valid_i` input N: request valid, one bit per requester.
- `req_ready_o` output N: request accepted; one-hot or zero.
- `req_data_i` input N x data_t: payload, one per requester.
- `out_valid_o` output 1: output payload valid.
- `out_ready_i` input 1: downstream accepts the output.
- `out_data_o` output data_t: output payload.
- `out_id_o` output ID_W: index of the requester that owns `out_data_o`.

## Operation

**State**
- `valid_q`: buffer full flag.
- `buf_q`: stored payload.
- `id_q`: stored requester index.
- `prio_q`: ID_W-bit index of the highest-priority requester.

**Write permission**
- `wok = ~valid_q | (FEEDTHROUGH & out_ready_i)`.

**Grant**
- Among the set bits of `req_valid_i`, pick the first one scanning from `prio_q` upward, modulo N.
- `req_ready_o[g] = wok`, only for the granted index g. All other ready bits are 0.
- No grant is produced when `req_valid_i == 0`.

**Requester handshake** (`req_valid_i[g] & req_ready_o[g]`)
- `prio_q <= (g+1) mod N`.
- With no handshake, `prio_q` holds, even while requests are pending.

**Buffer write enable**
- FEEDTHROUGH=0: `we = handshake & ~valid_q`.
- FEEDTHROUGH=1: `we = handshake & ~(valid_q ^ out_ready_i)`. The payload is stored when the buffer is empty and not read, or full and read in the same cycle.
- On `we`: `buf_q <= req_data_i[g]`, `id_q <= g`.

**Valid update**
- `valid_d = we | (valid_q & ~out_ready_i)`.

**Output**
- `out_valid_o = valid_q | (FEEDTHROUGH & |req_valid_i)`.
- `out_data_o` / `out_id_o`: equal `buf_q` / `id_q` when `valid_q`. When FEEDTHROUGH=1 and the buffer is empty, they equal `req_data_i[g]` / `g`.

**Requester rules**
- A requester holds `req_valid_i` and its data stable until it receives ready. The block does not check this.
- A request withdrawn before ready is a protocol violation. Behaviour in that case is undefined, but there must be no X on `valid_q`.

**N=1**
- `prio_q` is constant 0.
- Grant reduces to `req_valid_i[0]`.

## Timing

**Reset** (asynchronous, applies immediately, including mid-transfer)
- `valid_q=0`, `prio_q=0`, `out_valid_o=0` (FEEDTHROUGH=1: equals `|req_valid_i`).
- `req_ready_o=wok` for the grant winner.
- `buf_q` and `id_q` are not reset.
- A payload in flight at reset is dropped.

**FEEDTHROUGH=0**
- Latency: handshake in cycle t, `out_valid_o` in cycle t+1.
- No write while `valid_q=1`, even if `out_ready_i=1`. Peak throughput is one transfer every 2 cycles.

**FEEDTHROUGH=1**
- Latency: 0 cycles when empty.
- Throughput: 1 per cycle under continuous `out_ready_i`.

**Back-pressure**
- While full and `out_ready_i=0`, all `req_ready_o=0`.
- `out_data_o` and `out_id_o` hold stable.

**Combinational paths**
- `req_ready_o` depends combinationally on `req_valid_i`, on `out_ready_i` (FEEDTHROUGH=1 only) and on state.
- No path from `out_ready_i` to `out_valid_o`.

## Test plan

1. **Reset and first grant.** Reset, FEEDTHROUGH=0, N=4; all four requesters valid with data 0xA0..0xA3, `out_ready_i=1`.
   - Required: grants in order 0,1,2,3,0, one every 2 cycles.
   - `out_id_o` follows 0,1,2,3 with data A0..A3.
2. **Fairness skip.** Only requesters 1 and 3 valid, `prio_q=2`.
   - Required: grant 3, then 1, then 3.
   - Requesters 0 and 2 never see ready.
3. **Back-pressure.** Buffer full with id 2, `out_ready_i=0` for 5 cycles, requester 0 valid.
   - Required: `req_ready_o=0`; output stable (id 2) for all 5 cycles.
   - On release: output accepted, requester 0 granted on the following cycle (FEEDTHROUGH=0) or the same cycle (FEEDTHROUGH=1).
4. **Feedthrough streaming.** FEEDTHROUGH=1; requester 2 alone valid for 4 cycles, `out_ready_i=1`.
   - Required: `valid_q` stays 0.
   - 4 payloads appear in the same cycle as their requests, `out_id_o=2`.
5. **Feedthrough store and drain.** FEEDTHROUGH=1; `out_ready_i=0` while requester 1 is valid with 0x55.
   - Required: stored, `valid_q=1`.
   - Next cycle, `out_ready_i=1` with requester 0 valid with 0x66: output 0x55 and store 0x66 in the same cycle. `valid_q` stays 1, id becomes 0.
6. **Reset mid-operation.** Assert `rst_ni=0` while full and back-pressured.
   - Required: immediately `valid_q=0` and `prio_q=0`.
   - After release, requester 0 wins first.
